led_pattern_gen: RTL

- Parametrised multi-channel LED driver; the successor to the fixed 4-LED, single-rate blinker.
- Each channel has an independent mode: OFF, ON, BLINK (toggles on a shared prescaler tick) or PWM (static duty for brightness).
- Sits directly between board clock and LED pins.
- Mode and duty come from top-level straps or a later register block.

---
 rtl/led_pkg.sv | 11 +
 rtl/led_prescaler.sv | 30 +++
 rtl/led_pattern_gen.sv | 74 +++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared mode encoding for the LED pattern generator family.
package led_pkg;
    localparam int LED_MODE_W = 2;

    typedef logic [LED_MODE_W-1:0] led_mode_t;

    localparam led_mode_t LED_OFF   = 2'd0;
    localparam led_mode_t LED_ON    = 2'd1;
    localparam led_mode_t LED_BLINK = 2'd2;
    localparam led_mode_t LED_PWM   = 2'd3;
endpackage

// File: rtl/led_prescaler.sv
// Divide-by-TICK_DIV prescaler; tick is combinational in the terminal-count cycle.
// Tick is suppressed while disabled or while clr is asserted, so clr always wins.
module led_prescaler #(
    parameter int TICK_DIV = 10000000,
    parameter int CNT_W    = 24
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;
    logic             at_term;

    assign at_term = (count == TERM);
    assign tick    = en & ~clr & at_term;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= at_term ? '0 : count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: per-channel OFF / ON / BLINK / PWM, registered outputs.
// en low freezes all counters and blanks the LEDs; restart re-aligns everything.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int NUM_LEDS = 4,
    parameter int TICK_DIV = 10000000,
    parameter int CNT_W    = 24,
    parameter int PWM_W    = 8
) (
    input  logic                           clk_in,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic                           restart,
    input  logic [LED_MODE_W*NUM_LEDS-1:0] mode,
    input  logic [PWM_W*NUM_LEDS-1:0]      duty,
    output logic [NUM_LEDS-1:0]            led,
    output logic                           tick
);
    logic                tick_int;
    logic [PWM_W-1:0]    pwm_cnt;
    logic [NUM_LEDS-1:0] phase;
    logic [NUM_LEDS-1:0] phase_nxt;
    logic [NUM_LEDS-1:0] led_nxt;

    led_prescaler #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .en     (en),
        .clr    (restart),
        .tick   (tick_int)
    );

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        led_mode_t        ch_mode;
        logic [PWM_W-1:0] ch_duty;
        logic             ch_lit;

        assign ch_mode = mode[LED_MODE_W*i +: LED_MODE_W];
        assign ch_duty = duty[PWM_W*i +: PWM_W];

        assign ch_lit = (ch_mode == LED_ON)
                      | ((ch_mode == LED_BLINK) & phase[i])
                      | ((ch_mode == LED_PWM) & (pwm_cnt < ch_duty));

        // Phase is held at 0 outside BLINK so every entry into BLINK starts dark.
        assign phase_nxt[i] = restart ? 1'b0 :
                              !en     ? phase[i] :
                              (ch_mode == LED_BLINK) & (phase[i] ^ tick_int);

        assign led_nxt[i] = en & ch_lit;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            phase   <= '0;
            led     <= '0;
            tick    <= 1'b0;
        end else begin
            if (restart) begin
                pwm_cnt <= '0;
            end else if (en) begin
                pwm_cnt <= pwm_cnt + PWM_W'(1);
            end
            phase <= phase_nxt;
            led   <= led_nxt;
            tick  <= tick_int;
        end
    end
endmodule
